// File: rtl/mem_host_port.sv
// Host command port: bridges a valid/ready command/response channel to separate
// instruction- and data-memory strobes, and gates CPU execution for counted runs.
module mem_host_port #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,

    input  logic              run_abort,

    output logic [DATA_W-1:0] addr_ext,
    output logic              wen_ext,
    output logic              ren_ext,
    output logic [DATA_W-1:0] wdata_ext,
    input  logic [DATA_W-1:0] rdata_ext,

    output logic [DATA_W-1:0] addr_ext_2,
    output logic              wen_ext_2,
    output logic              ren_ext_2,
    output logic [DATA_W-1:0] wdata_ext_2,
    input  logic [DATA_W-1:0] rdata_ext_2,

    output logic              enable
);

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StRdReq,
        StRdWait,
        StRun,
        StRsp
    } state_e;

    state_e            state_q, state_d;
    logic              dmem_q, dmem_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              err_q, err_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rdy_q;

    always_comb begin
        state_d = state_q;
        dmem_d  = dmem_q;
        addr_d  = addr_q;
        data_d  = data_q;
        res_d   = res_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready) begin
                    dmem_d = cmd_op[1];
                    addr_d = cmd_addr;
                    data_d = cmd_data;
                    res_d  = '0;
                    err_d  = 1'b0;
                    case (cmd_op)
                        3'b000, 3'b010: state_d = StWr;
                        3'b001, 3'b011: state_d = StRdReq;
                        3'b100:         state_d = (cmd_data != '0) ? StRun : StRsp;
                        default: begin
                            err_d   = 1'b1;
                            state_d = StRsp;
                        end
                    endcase
                end
            end
            StWr:    state_d = StRsp;
            StRdReq: state_d = StRdWait;
            StRdWait: begin
                res_d   = dmem_q ? rdata_ext_2 : rdata_ext;
                state_d = StRsp;
            end
            StRun: begin
                // res_q doubles as the enable-cycle counter; this cycle is counted even on abort
                res_d = res_q + DATA_W'(1);
                if (run_abort || (res_d == data_q)) begin
                    state_d = StRsp;
                end
            end
            StRsp: begin
                if (rsp_valid_q && rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Response becomes visible one cycle after entering StRsp and drops on transfer
    assign rsp_valid_d = (state_q == StRsp) && !(rsp_valid_q && rsp_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            dmem_q      <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            res_q       <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdy_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dmem_q      <= dmem_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            res_q       <= res_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            rdy_q       <= 1'b1;
        end
    end

    assign cmd_ready = rdy_q && (state_q == StIdle);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_valid_q ? res_q : '0;
    assign rsp_err   = rsp_valid_q && err_q;
    assign enable    = (state_q == StRun);

    assign wen_ext   = (state_q == StWr)    && !dmem_q;
    assign ren_ext   = (state_q == StRdReq) && !dmem_q;
    assign wen_ext_2 = (state_q == StWr)    && dmem_q;
    assign ren_ext_2 = (state_q == StRdReq) && dmem_q;

    assign addr_ext    = (wen_ext || ren_ext) ? addr_q : '0;
    assign wdata_ext   = wen_ext ? data_q : '0;
    assign addr_ext_2  = (wen_ext_2 || ren_ext_2) ? addr_q : '0;
    assign wdata_ext_2 = wen_ext_2 ? data_q : '0;

endmodule
